// File: rtl/vscale_htif_pcr_if.sv
// HTIF PCR request/response bundle between the host harness and the core-side responder.
// The host drives requests and accepts responses (master).
// The responder accepts requests and returns one response per request (slave).
interface vscale_htif_pcr_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
);
  logic              htif_pcr_req_valid;
  logic              htif_pcr_req_ready;
  logic              htif_pcr_req_rw;
  logic [ADDR_W-1:0] htif_pcr_req_addr;
  logic [DATA_W-1:0] htif_pcr_req_data;
  logic              htif_pcr_resp_valid;
  logic              htif_pcr_resp_ready;
  logic [DATA_W-1:0] htif_pcr_resp_data;

  modport master (
    output htif_pcr_req_valid,
    output htif_pcr_req_rw,
    output htif_pcr_req_addr,
    output htif_pcr_req_data,
    output htif_pcr_resp_ready,
    input  htif_pcr_req_ready,
    input  htif_pcr_resp_valid,
    input  htif_pcr_resp_data
  );

  modport slave (
    input  htif_pcr_req_valid,
    input  htif_pcr_req_rw,
    input  htif_pcr_req_addr,
    input  htif_pcr_req_data,
    input  htif_pcr_resp_ready,
    output htif_pcr_req_ready,
    output htif_pcr_resp_valid,
    output htif_pcr_resp_data
  );
endinterface

// File: rtl/vscale_htif_pcr_responder.sv
// Core-side responder for HTIF PCR requests. It owns the tohost and fromhost registers.
// Each accepted host request performs a swap-style access and returns the register's
// previous value. A tohost read may optionally clear the register. The core can write
// tohost and clear fromhost through a side port.
module vscale_htif_pcr_responder #(
  parameter int unsigned          DATA_W        = 64,
  parameter int unsigned          ADDR_W        = 12,
  parameter logic [ADDR_W-1:0]    TOHOST_ADDR   = 12'h780,
  parameter logic [ADDR_W-1:0]    FROMHOST_ADDR = 12'h781,
  parameter bit                   CLEAR_ON_READ = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  vscale_htif_pcr_if.slave        htif,
  input  logic                    core_tohost_wen,
  input  logic [DATA_W-1:0]       core_tohost_wdata,
  input  logic                    core_fromhost_clr,
  output logic [DATA_W-1:0]       tohost,
  output logic [DATA_W-1:0]       fromhost
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              req_fire;
  logic              hit_tohost;
  logic              hit_fromhost;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] tohost_q;
  logic [DATA_W-1:0] fromhost_q;
  logic [DATA_W-1:0] resp_data_q;

  assign hit_tohost   = (htif.htif_pcr_req_addr == TOHOST_ADDR);
  assign hit_fromhost = (htif.htif_pcr_req_addr == FROMHOST_ADDR);

  // State register; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake decode. Accept only in IDLE and hold the response until the host takes it.
  always_comb begin
    state_d                  = state_q;
    req_fire                 = 1'b0;
    htif.htif_pcr_req_ready  = 1'b0;
    htif.htif_pcr_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        htif.htif_pcr_req_ready = reset;
        if (reset && htif.htif_pcr_req_valid) begin
          req_fire = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        htif.htif_pcr_resp_valid = reset;
        if (htif.htif_pcr_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pre-access value of the addressed register. Unmapped addresses read as zero.
  always_comb begin
    rd_old = '0;
    if (hit_tohost) begin
      rd_old = tohost_q;
    end else if (hit_fromhost) begin
      rd_old = fromhost_q;
    end
  end

  // Register updates. A core tohost write beats any host access in the same cycle.
  // A host fromhost write beats a core clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tohost_q    <= '0;
      fromhost_q  <= '0;
      resp_data_q <= '0;
    end else begin
      if (req_fire) begin
        resp_data_q <= rd_old;
      end

      if (core_tohost_wen) begin
        tohost_q <= core_tohost_wdata;
      end else if (req_fire && hit_tohost) begin
        if (htif.htif_pcr_req_rw) begin
          tohost_q <= htif.htif_pcr_req_data;
        end else if (CLEAR_ON_READ) begin
          tohost_q <= '0;
        end
      end

      if (req_fire && hit_fromhost && htif.htif_pcr_req_rw) begin
        fromhost_q <= htif.htif_pcr_req_data;
      end else if (core_fromhost_clr) begin
        fromhost_q <= '0;
      end
    end
  end

  assign htif.htif_pcr_resp_data = resp_data_q;
  assign tohost                  = tohost_q;
  assign fromhost                = fromhost_q;

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Testbench for vscale_htif_pcr_responder.
// A negedge reference model tracks tohost, fromhost and the busy state. Expected response
// data is queued at acceptance and compared while the response is held. Directed sequences
// exercise polling, fromhost traffic, backpressure, collisions, unmapped addresses and
// reset in the middle of a transaction.
module tb_vscale_htif_pcr_responder;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 12;
  localparam logic [ADDR_W-1:0] TO_A   = 12'h780;
  localparam logic [ADDR_W-1:0] FROM_A = 12'h781;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_tohost_wen;
  logic [DATA_W-1:0] core_tohost_wdata;
  logic              core_fromhost_clr;
  logic [DATA_W-1:0] tohost;
  logic [DATA_W-1:0] fromhost;

  vscale_htif_pcr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) htif ();

  vscale_htif_pcr_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .TOHOST_ADDR(TO_A), .FROMHOST_ADDR(FROM_A), .CLEAR_ON_READ(1'b1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .htif              (htif),
    .core_tohost_wen   (core_tohost_wen),
    .core_tohost_wdata (core_tohost_wdata),
    .core_fromhost_clr (core_fromhost_clr),
    .tohost            (tohost),
    .fromhost          (fromhost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] m_to   = '0;
  logic [DATA_W-1:0] m_from = '0;
  logic              m_busy = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  // Model: compare outputs against the state after the last edge, then step the model for the next edge.
  always @(negedge clk) begin
    logic [DATA_W-1:0] old_v, n_to, n_from;
    logic acc;
    chk("mon_resp_valid", {63'd0, htif.htif_pcr_resp_valid}, {63'd0, reset & m_busy});
    chk("mon_req_ready",  {63'd0, htif.htif_pcr_req_ready},  {63'd0, reset & ~m_busy});
    chk("mon_tohost",   tohost,   m_to);
    chk("mon_fromhost", fromhost, m_from);
    if (!reset) begin
      m_to   = '0;
      m_from = '0;
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      acc    = 1'b0;
      n_to   = m_to;
      n_from = m_from;
      if (m_busy) begin
        if (exp_q.size() == 0) begin
          chk("mon_resp_unexpected", htif.htif_pcr_resp_data, '1);
        end else begin
          chk("mon_resp_data", htif.htif_pcr_resp_data, exp_q[0]);
          if (htif.htif_pcr_resp_ready) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
          end
        end
      end else if (htif.htif_pcr_req_valid) begin
        acc   = 1'b1;
        old_v = (htif.htif_pcr_req_addr == TO_A) ? m_to :
                (htif.htif_pcr_req_addr == FROM_A) ? m_from : '0;
        exp_q.push_back(old_v);
        if (htif.htif_pcr_req_addr == TO_A)
          n_to = htif.htif_pcr_req_rw ? htif.htif_pcr_req_data : '0;
        m_busy = 1'b1;
      end
      if (core_tohost_wen) n_to = core_tohost_wdata;
      if (core_fromhost_clr) n_from = '0;
      if (acc && htif.htif_pcr_req_rw && htif.htif_pcr_req_addr == FROM_A)
        n_from = htif.htif_pcr_req_data;
      m_to   = n_to;
      m_from = n_from;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE, then check the response that follows.
  task automatic host_req(input string tag, input logic rw, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp);
    int w = 0;
    while (!htif.htif_pcr_req_ready && w < 20) begin
      tick(1);
      w++;
    end
    if (!htif.htif_pcr_req_ready) chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
    htif.htif_pcr_req_valid = 1'b1;
    htif.htif_pcr_req_rw    = rw;
    htif.htif_pcr_req_addr  = addr;
    htif.htif_pcr_req_data  = data;
    tick(1);
    htif.htif_pcr_req_valid = 1'b0;
    chk({tag, "_resp_valid"}, {63'd0, htif.htif_pcr_resp_valid}, 64'd1);
    chk({tag, "_resp_data"},  htif.htif_pcr_resp_data, exp);
  endtask

  initial begin
    reset                    = 1'b0;
    htif.htif_pcr_req_valid  = 1'b0;
    htif.htif_pcr_req_rw     = 1'b0;
    htif.htif_pcr_req_addr   = '0;
    htif.htif_pcr_req_data   = '0;
    htif.htif_pcr_resp_ready = 1'b1;
    core_tohost_wen          = 1'b0;
    core_tohost_wdata        = '0;
    core_fromhost_clr        = 1'b0;

    // Reset for 3 cycles
    tick(3);
    chk("rst_tohost",     tohost, 64'd0);
    chk("rst_fromhost",   fromhost, 64'd0);
    chk("rst_resp_valid", {63'd0, htif.htif_pcr_resp_valid}, 64'd0);
    chk("rst_resp_data",  htif.htif_pcr_resp_data, 64'd0);
    chk("rst_req_ready",  {63'd0, htif.htif_pcr_req_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("rel_req_ready",  {63'd0, htif.htif_pcr_req_ready}, 64'd1);

    // Polling tohost with valid/ready tied high: one response every other cycle
    htif.htif_pcr_req_valid = 1'b1;
    htif.htif_pcr_req_rw    = 1'b0;
    htif.htif_pcr_req_addr  = TO_A;
    tick(1);
    chk("poll_first_valid", {63'd0, htif.htif_pcr_resp_valid}, 64'd1);
    tick(1);
    chk("poll_gap_valid",   {63'd0, htif.htif_pcr_resp_valid}, 64'd0);
    tick(1);
    chk("poll_second_valid", {63'd0, htif.htif_pcr_resp_valid}, 64'd1);
    chk("poll_second_data",  htif.htif_pcr_resp_data, 64'd0);
    htif.htif_pcr_req_valid = 1'b0;
    tick(2);

    // Core writes tohost; the host read returns it and clears it
    core_tohost_wen   = 1'b1;
    core_tohost_wdata = 64'h15;
    tick(1);
    core_tohost_wen   = 1'b0;
    chk("core_wr_tohost", tohost, 64'h15);
    host_req("poll_15", 1'b0, TO_A, '0, 64'h15);
    chk("poll_cleared", tohost, 64'd0);
    tick(1);
    host_req("poll_after_clr", 1'b0, TO_A, '0, 64'd0);
    tick(1);

    // Fromhost write/read and core clear
    host_req("fh_write", 1'b1, FROM_A, 64'hABCD, 64'd0);
    chk("fh_value", fromhost, 64'hABCD);
    tick(1);
    host_req("fh_read", 1'b0, FROM_A, '0, 64'hABCD);
    chk("fh_read_keeps", fromhost, 64'hABCD);
    tick(1);
    core_fromhost_clr = 1'b1;
    tick(1);
    core_fromhost_clr = 1'b0;
    chk("fh_core_clr", fromhost, 64'd0);

    // Backpressure: response held, new requests ignored
    htif.htif_pcr_resp_ready = 1'b0;
    host_req("bp_req", 1'b1, FROM_A, 64'h1234, 64'd0);
    htif.htif_pcr_req_valid = 1'b1;
    htif.htif_pcr_req_rw    = 1'b1;
    htif.htif_pcr_req_addr  = TO_A;
    htif.htif_pcr_req_data  = 64'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_valid", {63'd0, htif.htif_pcr_resp_valid}, 64'd1);
      chk("bp_data",  htif.htif_pcr_resp_data, 64'd0);
      chk("bp_ready", {63'd0, htif.htif_pcr_req_ready}, 64'd0);
      chk("bp_tohost", tohost, 64'd0);
    end
    htif.htif_pcr_req_valid  = 1'b0;
    htif.htif_pcr_resp_ready = 1'b1;
    tick(1);
    chk("bp_rel_valid", {63'd0, htif.htif_pcr_resp_valid}, 64'd0);
    chk("bp_rel_ready", {63'd0, htif.htif_pcr_req_ready}, 64'd1);
    chk("bp_fromhost",  fromhost, 64'h1234);

    // Collision: host read-clear of tohost together with a core write
    host_req("col_set7", 1'b1, TO_A, 64'd7, 64'd0);
    tick(1);
    htif.htif_pcr_req_valid = 1'b1;
    htif.htif_pcr_req_rw    = 1'b0;
    htif.htif_pcr_req_addr  = TO_A;
    core_tohost_wen         = 1'b1;
    core_tohost_wdata       = 64'd9;
    tick(1);
    htif.htif_pcr_req_valid = 1'b0;
    core_tohost_wen         = 1'b0;
    chk("col_resp", htif.htif_pcr_resp_data, 64'd7);
    chk("col_tohost", tohost, 64'd9);
    tick(1);

    // Host fromhost write beats a core clear
    htif.htif_pcr_req_valid = 1'b1;
    htif.htif_pcr_req_rw    = 1'b1;
    htif.htif_pcr_req_addr  = FROM_A;
    htif.htif_pcr_req_data  = 64'h77;
    core_fromhost_clr       = 1'b1;
    tick(1);
    htif.htif_pcr_req_valid = 1'b0;
    core_fromhost_clr       = 1'b0;
    chk("col_fh_resp", htif.htif_pcr_resp_data, 64'h1234);
    chk("col_fromhost", fromhost, 64'h77);
    tick(1);

    // Unmapped address
    host_req("unmap_wr", 1'b1, 12'h123, 64'h55, 64'd0);
    chk("unmap_tohost", tohost, 64'd9);
    chk("unmap_fromhost", fromhost, 64'h77);
    tick(1);
    host_req("unmap_rd", 1'b0, 12'h123, '0, 64'd0);
    tick(1);

    // Reset while a response is pending
    htif.htif_pcr_resp_ready = 1'b0;
    host_req("mid_req", 1'b0, FROM_A, '0, 64'h77);
    reset = 1'b0;
    tick(1);
    chk("mid_resp_valid", {63'd0, htif.htif_pcr_resp_valid}, 64'd0);
    chk("mid_tohost",   tohost, 64'd0);
    chk("mid_fromhost", fromhost, 64'd0);
    chk("mid_resp_data", htif.htif_pcr_resp_data, 64'd0);
    reset = 1'b1;
    htif.htif_pcr_resp_ready = 1'b1;
    tick(1);
    chk("mid_rel_valid", {63'd0, htif.htif_pcr_resp_valid}, 64'd0);
    host_req("mid_after", 1'b0, TO_A, '0, 64'd0);
    tick(3);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vscale_htif_pcr_responder.md
Name: vscale_htif_pcr_responder

Overview:
Core-side responder for the HTIF PCR request/response interface. It accepts host CSR requests, services the tohost/fromhost registers, and returns exactly one response per request. It sits between the core's CSR file and the host harness, which polls tohost and writes fromhost. It owns both registers and exposes them to the core through a simple write/clear port.

Parameters:
DATA_W, 64, PCR data width (matches HTIF_PCR_WIDTH)
ADDR_W, 12, CSR address width
TOHOST_ADDR, 12'h780, CSR address of tohost
FROMHOST_ADDR, 12'h781, CSR address of fromhost
CLEAR_ON_READ, 1, when 1 a host read of tohost clears it

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
htif_pcr_req_valid  in  1  host request valid
htif_pcr_req_ready  out  1  responder can accept a request
htif_pcr_req_rw  in  1  1 = write, 0 = read
htif_pcr_req_addr  in  ADDR_W  CSR address
htif_pcr_req_data  in  DATA_W  write data
htif_pcr_resp_valid  out  1  response valid
htif_pcr_resp_ready  in  1  host accepts response
htif_pcr_resp_data  out  DATA_W  response data
core_tohost_wen  in  1  core writes tohost
core_tohost_wdata  in  DATA_W  core tohost write data
core_fromhost_clr  in  1  core clears fromhost after consuming it
tohost  out  DATA_W  current tohost value
fromhost  out  DATA_W  current fromhost value

Behaviour:
- Reset (reset==0 at posedge clk):
  - State = IDLE.
  - tohost = 0, fromhost = 0, resp_valid = 0, resp_data = 0, req_ready = 0 during reset.
  - Reset asserted mid-transaction drops any pending response; no partial effect is retained.
- FSM with two states.
  - IDLE: req_ready = 1, resp_valid = 0.
    - On req_valid && req_ready: perform the access at that edge, load resp_data, go to RESP.
  - RESP: req_ready = 0, resp_valid = 1, resp_data held stable.
    - On resp_ready: go to IDLE.
- Latency: resp_valid rises on the cycle after acceptance.
  - Minimum spacing between accepted requests is 2 cycles; no pipelining.
  - With req_valid and resp_ready tied to 1, a request is accepted every other cycle.
- Access semantics. resp_data always returns the register value before the access (swap semantics for writes).
  - Read TOHOST_ADDR: return tohost. If CLEAR_ON_READ, tohost := 0.
  - Write TOHOST_ADDR: tohost := req_data.
  - Read FROMHOST_ADDR: return fromhost, no side effect.
  - Write FROMHOST_ADDR: fromhost := req_data.
  - Any other address: read returns 0, write is ignored, and a response is still issued.
- Core port:
  - core_tohost_wen updates tohost at the edge.
  - core_fromhost_clr sets fromhost := 0.
- Simultaneous events at the same edge:
  - core_tohost_wen with a host read-clear or host write of tohost: the core value wins; the response still carries the old value.
  - Host write of fromhost with core_fromhost_clr: the host write wins.
- tohost/fromhost outputs are direct register outputs, updated the cycle after the edge that changes them.
- Inputs are ignored while in RESP; req_* may change freely there.

Test Plan:
- Reset, then check outputs: assert reset low for 3 cycles → tohost=0, fromhost=0, resp_valid=0; first cycle after release req_ready=1.
- Polling tohost: req_valid=1, rw=0, addr=780, resp_ready=1 tied, no core write → resp_valid every other cycle with data 0.
  - Then core writes 0x15 → the next response carries 0x15, tohost reads 0 afterwards, and the following response carries 0.
- Fromhost write/read: write 781 data 0xABCD → resp 0 (old value), fromhost output = 0xABCD.
  - A following read → resp 0xABCD.
  - Then core_fromhost_clr → fromhost = 0.
- Response backpressure: resp_ready held 0 for 5 cycles → resp_valid and resp_data stable, req_ready=0, new req_valid ignored.
  - Release resp_ready → IDLE next cycle.
- Collision: host read of tohost (value 7) in the same cycle as core_tohost_wen=1 with 9 → resp_data 7, tohost 9.
  - Unmapped address 0x123 write 0x55 → resp 0, no register changes.
- Mid-transaction reset: reset asserted while in RESP → resp_valid=0 the next cycle, registers 0; after release, a read of 780 returns 0.
